axi_burst_dispatcher: RTL and testbench
=======================================

AXI_BURST_DISPATCHER -- requirements
Module: axi_burst_dispatcher

Interface
REQ-001 SHALL have parameter P_REQUESTER_NUM, default 4, number of upstream requesters (>=2).
REQ-002 SHALL have parameter P_DATA_W, default 32, beat payload width.
REQ-003 SHALL have parameter P_NUM_GRANT_REQ_W, default 3, burst-length field width (max burst 2**P_NUM_GRANT_REQ_W-1 beats).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port m_valid_i  in  P_REQUESTER_NUM  per-requester beat valid.
REQ-007 SHALL have port m_data_i  in  P_REQUESTER_NUM*P_DATA_W  per-requester beat payload; requester i at bits [i*P_DATA_W +: P_DATA_W].
REQ-008 SHALL have port m_len_i  in  P_REQUESTER_NUM*P_NUM_GRANT_REQ_W  per-requester burst beat count; sampled at grant.
REQ-009 SHALL have port m_ready_o  out  P_REQUESTER_NUM  per-requester beat accept.
REQ-010 SHALL have port arb_req_o  out  P_REQUESTER_NUM  request vector to weighted round-robin arbiter.
REQ-011 SHALL have port arb_num_grant_req_o  out  P_NUM_GRANT_REQ_W  weight consumed by current grant.
REQ-012 SHALL have port arb_grant_ready_o  out  1  commit strobe to arbiter.
REQ-013 SHALL have port arb_grant_valid_i  in  P_REQUESTER_NUM  one-hot (or zero) combinational grant from arbiter.
REQ-014 SHALL have ports s_valid_o out 1, s_data_o out P_DATA_W, s_id_o out clog2(P_REQUESTER_NUM), s_last_o out 1, s_ready_i in 1: downstream beat channel.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, BURST.
REQ-016 In IDLE: arb_req_o = m_valid_i; m_ready_o = 0; s_valid_o = 0.
REQ-017 In IDLE with arb_grant_valid_i nonzero: arb_grant_ready_o = 1 same cycle; arb_num_grant_req_o = effective length of granted requester; next cycle state = BURST, sel_r = encoded grant, beat_cnt_r = effective length.
REQ-018 Effective length = m_len_i field of granted requester; value 0 treated as 1.
REQ-019 arb_grant_ready_o SHALL be 0 in every other cycle; arb_num_grant_req_o = 0 when arb_grant_ready_o = 0.
REQ-020 In BURST: arb_req_o = 0; s_valid_o = m_valid_i[sel_r]; s_data_o = payload of sel_r; s_id_o = sel_r; m_ready_o[sel_r] = s_ready_i, other bits 0 (combinational pass-through, zero added latency).
REQ-021 s_last_o = 1 iff BURST and beat_cnt_r == 1.
REQ-022 Beat handshake (s_valid_o & s_ready_i) in BURST SHALL decrement beat_cnt_r by 1; handshake with beat_cnt_r == 1 SHALL return FSM to IDLE next cycle.
REQ-023 Grant-to-first-beat latency SHALL be exactly one cycle; one idle cycle between consecutive bursts.
REQ-024 Selection SHALL remain locked to sel_r for the whole burst regardless of other requesters' valids or m_len_i changes.
REQ-025 Requester deasserting m_valid_i mid-burst SHALL stall the burst (s_valid_o = 0), not abort it.
REQ-026 m_valid_i deasserted by the granted requester in the grant cycle has no effect; burst proceeds.
REQ-027 s_data_o, s_id_o SHALL be 0 when s_valid_o = 0.

Reset
REQ-028 rst = 1 SHALL force IDLE, sel_r = 0, beat_cnt_r = 0 on next edge, including mid-burst; partially forwarded burst is abandoned.
REQ-029 While in reset state: m_ready_o = 0, s_valid_o = 0, s_last_o = 0, arb_grant_ready_o = 0, arb_num_grant_req_o = 0.

Verification
REQ-030 Single requester 1, m_len=3, s_ready=1 -> grant cycle with arb_grant_ready_o=1, arb_num_grant_req_o=3; then 3 beats s_id_o=1, s_last_o only on 3rd; IDLE after.
REQ-031 m_len=0 on requester 2 -> treated as 1: arb_num_grant_req_o=1, single beat with s_last_o=1.
REQ-032 Requesters 0 and 3 valid, grant to 0 with m_len=4, s_ready toggling 1/0 -> exactly 4 handshakes from requester 0, m_ready_o[3]=0 throughout, arb_req_o=0 during burst.
REQ-033 Granted requester drops m_valid_i for 2 cycles mid-burst -> s_valid_o=0 for those cycles, beat_cnt_r held, burst completes.
REQ-034 rst asserted after 2 of 5 beats -> next cycle IDLE, all outputs at reset values; after release, fresh grant with new arb_grant_ready_o pulse.
REQ-035 Connected to a weighted round-robin arbiter (weights 5,3,2,1), all requesters valid, m_len=1 -> grant sequence matches arbiter's interleaving order; each grant one arb_grant_ready_o pulse.

Source files
------------

// File: rtl/axi_burst_dispatcher.sv
// ---------------------------------------------------------------------------
// axi_burst_dispatcher
//
// Forwards whole bursts from one of several upstream requesters to a single
// downstream beat channel. An external weighted round-robin arbiter picks the
// requester; the dispatcher commits the grant, then locks onto the winner and
// forwards its beats until the burst length captured at grant is used up.
//
// Ports
//   clk, rst              : single clock, synchronous active-high reset
//   m_valid_i / m_ready_o : per-requester beat handshake
//   m_data_i              : per-requester payload, requester i at [i*P_DATA_W +: P_DATA_W]
//   m_len_i               : per-requester burst length (0 means 1), sampled at grant
//   arb_req_o             : request vector to the arbiter (IDLE only)
//   arb_grant_valid_i     : one-hot (or zero) combinational grant from the arbiter
//   arb_grant_ready_o     : one-cycle commit strobe back to the arbiter
//   arb_num_grant_req_o   : weight consumed by the committed grant
//   s_valid_o, s_data_o, s_id_o, s_last_o, s_ready_i : downstream beat channel
// ---------------------------------------------------------------------------
module axi_burst_dispatcher #(
    parameter int P_REQUESTER_NUM   = 4,
    parameter int P_DATA_W          = 32,
    parameter int P_NUM_GRANT_REQ_W = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [P_REQUESTER_NUM-1:0]               m_valid_i,
    input  logic [P_REQUESTER_NUM*P_DATA_W-1:0]      m_data_i,
    input  logic [P_REQUESTER_NUM*P_NUM_GRANT_REQ_W-1:0] m_len_i,
    output logic [P_REQUESTER_NUM-1:0]               m_ready_o,
    output logic [P_REQUESTER_NUM-1:0]               arb_req_o,
    output logic [P_NUM_GRANT_REQ_W-1:0]             arb_num_grant_req_o,
    output logic                                     arb_grant_ready_o,
    input  logic [P_REQUESTER_NUM-1:0]               arb_grant_valid_i,
    output logic                                     s_valid_o,
    output logic [P_DATA_W-1:0]                      s_data_o,
    output logic [$clog2(P_REQUESTER_NUM)-1:0]       s_id_o,
    output logic                                     s_last_o,
    input  logic                                     s_ready_i
);

    localparam int ID_W  = $clog2(P_REQUESTER_NUM);
    localparam int LEN_W = P_NUM_GRANT_REQ_W;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   sel_r, sel_d;
    logic [LEN_W-1:0]  beat_cnt_r, beat_cnt_d;

    logic [ID_W-1:0]   grant_idx;
    logic [LEN_W-1:0]  grant_len;
    logic              sel_valid;
    logic [P_DATA_W-1:0] sel_data;

    // Encode the arbiter grant and fetch the granted requester's length.
    // A zero length field still moves one beat.
    always_comb begin
        grant_idx = '0;
        grant_len = '0;
        for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
            if (arb_grant_valid_i[i]) begin
                grant_idx = ID_W'(i);
                grant_len = m_len_i[i*LEN_W +: LEN_W];
            end
        end
        if (grant_len == '0) begin
            grant_len = LEN_W'(1);
        end
    end

    // Mux of the locked requester's valid and payload.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
            if (ID_W'(i) == sel_r) begin
                sel_valid = m_valid_i[i];
                sel_data  = m_data_i[i*P_DATA_W +: P_DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_r      <= '0;
            beat_cnt_r <= '0;
        end else begin
            state_q    <= state_d;
            sel_r      <= sel_d;
            beat_cnt_r <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        sel_d               = sel_r;
        beat_cnt_d          = beat_cnt_r;
        arb_req_o           = '0;
        arb_grant_ready_o   = 1'b0;
        arb_num_grant_req_o = '0;
        m_ready_o           = '0;
        s_valid_o           = 1'b0;
        s_data_o            = '0;
        s_id_o              = '0;
        s_last_o            = 1'b0;

        case (state_q)
            IDLE: begin
                arb_req_o = m_valid_i;
                // The grant is committed regardless of the winner's valid in
                // this cycle; the burst then waits for its beats.
                if (|arb_grant_valid_i) begin
                    arb_grant_ready_o   = 1'b1;
                    arb_num_grant_req_o = grant_len;
                    state_d             = BURST;
                    sel_d               = grant_idx;
                    beat_cnt_d          = grant_len;
                end
            end
            BURST: begin
                s_valid_o = sel_valid;
                s_last_o  = (beat_cnt_r == LEN_W'(1));
                if (sel_valid) begin
                    s_data_o = sel_data;
                    s_id_o   = sel_r;
                end
                for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
                    m_ready_o[i] = s_ready_i && (ID_W'(i) == sel_r);
                end
                if (sel_valid && s_ready_i) begin
                    beat_cnt_d = beat_cnt_r - LEN_W'(1);
                    if (beat_cnt_r == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_burst_dispatcher.sv
module tb_axi_burst_dispatcher;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int LW  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_valid_i;
    logic [N*DW-1:0]   m_data_i;
    logic [N*LW-1:0]   m_len_i;
    logic [N-1:0]      m_ready_o;
    logic [N-1:0]      arb_req_o;
    logic [LW-1:0]     arb_num_grant_req_o;
    logic              arb_grant_ready_o;
    logic [N-1:0]      arb_grant_valid_i;
    logic              s_valid_o;
    logic [DW-1:0]     s_data_o;
    logic [1:0]        s_id_o;
    logic              s_last_o;
    logic              s_ready_i;

    axi_burst_dispatcher #(
        .P_REQUESTER_NUM  (N),
        .P_DATA_W         (DW),
        .P_NUM_GRANT_REQ_W(LW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .m_valid_i          (m_valid_i),
        .m_data_i           (m_data_i),
        .m_len_i            (m_len_i),
        .m_ready_o          (m_ready_o),
        .arb_req_o          (arb_req_o),
        .arb_num_grant_req_o(arb_num_grant_req_o),
        .arb_grant_ready_o  (arb_grant_ready_o),
        .arb_grant_valid_i  (arb_grant_valid_i),
        .s_valid_o          (s_valid_o),
        .s_data_o           (s_data_o),
        .s_id_o             (s_id_o),
        .s_last_o           (s_last_o),
        .s_ready_i          (s_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        bit          last;
    } beat_t;

    beat_t exp_beats[$];
    int    exp_grants[$];

    int checks = 0;
    int errors = 0;

    // Transaction-level model of what the dispatcher should be doing.
    bit model_active = 0;
    bit model_grant  = 0;
    int model_r      = 0;
    int model_rem    = 0;

    // Bench-side arbiter: random pick mode or weighted round-robin mode.
    bit grant_en    = 0;
    bit force_grant = 0;
    int pick        = 0;
    bit wrr_mode    = 0;
    int wrr_ptr;
    int wrr_credit;
    int weights[N] = '{5, 3, 2, 1};

    always_comb begin
        arb_grant_valid_i = '0;
        if (wrr_mode) begin
            if (arb_req_o[wrr_ptr]) arb_grant_valid_i[wrr_ptr] = 1'b1;
        end else if (grant_en && (force_grant || arb_req_o[pick])) begin
            arb_grant_valid_i[pick] = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!wrr_mode) begin
            wrr_ptr    <= 0;
            wrr_credit <= weights[0];
        end else if (arb_grant_ready_o) begin
            if (wrr_credit - int'(arb_num_grant_req_o) <= 0) begin
                wrr_ptr    <= (wrr_ptr + 1) % N;
                wrr_credit <= weights[(wrr_ptr + 1) % N];
            end else begin
                wrr_credit <= wrr_credit - int'(arb_num_grant_req_o);
            end
        end
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: samples on the falling edge, away from state updates.
    always @(negedge clk) begin
        logic [N-1:0] exp_mr;
        beat_t b;
        exp_mr = '0;
        if (model_active) exp_mr[model_r] = s_ready_i;

        chk("grant_ready", 64'(arb_grant_ready_o), 64'(model_grant));
        if (arb_grant_ready_o) begin
            if (exp_grants.size() == 0) begin
                chk("grant_unexpected", 64'(1), 64'(0));
            end else begin
                chk("grant_num", 64'(arb_num_grant_req_o), 64'(exp_grants.pop_front()));
            end
        end else begin
            chk("grant_num_idle", 64'(arb_num_grant_req_o), 64'(0));
        end

        chk("s_valid", 64'(s_valid_o), 64'(model_active && m_valid_i[model_r]));
        chk("m_ready", 64'(m_ready_o), 64'(exp_mr));
        chk("arb_req", 64'(arb_req_o), model_active ? 64'(0) : 64'(m_valid_i));
        chk("s_last", 64'(s_last_o), 64'(model_active && model_rem == 1));

        if (s_valid_o && s_ready_i) begin
            if (exp_beats.size() == 0) begin
                chk("beat_unexpected", 64'(1), 64'(0));
            end else begin
                b = exp_beats.pop_front();
                chk("beat_id", 64'(s_id_o), 64'(b.id));
                chk("beat_data", 64'(s_data_o), 64'(b.data));
                chk("beat_last", 64'(s_last_o), 64'(b.last));
            end
        end else if (!s_valid_o) begin
            chk("idle_data_id", {32'(s_id_o), s_data_o}, 64'(0));
        end
    end

    // One burst from requester r. drop: r's valid is low in the grant cycle.
    // stalls: random valid/ready gaps. abort_after >= 0: reset after that many beats.
    task automatic do_burst(int r, int lenf, bit drop, bit stalls, int abort_after);
        int eff;
        int k;
        int guard;
        bit v;
        bit rdy;
        logic [31:0] d[8];
        eff = (lenf == 0) ? 1 : lenf;
        for (int i = 0; i < eff; i++) begin
            d[i] = $urandom;
            exp_beats.push_back('{id: r, data: d[i], last: (i == eff - 1)});
        end
        exp_grants.push_back(eff);

        for (int i = 0; i < N; i++) begin
            m_valid_i[i] = 1'($urandom_range(0, 1));
            m_len_i[i*LW +: LW] = LW'($urandom);
            m_data_i[i*DW +: DW] = $urandom;
        end
        m_valid_i[r] = !drop;
        m_len_i[r*LW +: LW] = LW'(lenf);
        s_ready_i = 1'($urandom_range(0, 1));
        pick = r;
        grant_en = 1;
        force_grant = drop;
        model_grant = 1;
        @(posedge clk); #1;
        grant_en = 0;
        force_grant = 0;
        model_grant = 0;
        model_active = 1;
        model_r = r;
        model_rem = eff;

        k = 0;
        guard = 0;
        while (k < eff && guard < 200) begin
            if (abort_after >= 0 && k == abort_after) begin
                m_valid_i[r] = 1'b1;
                s_ready_i = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                model_active = 0;
                exp_beats.delete();
                m_valid_i = '0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            v   = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            for (int i = 0; i < N; i++) begin
                if (i != r) m_valid_i[i] = 1'($urandom_range(0, 1));
                m_len_i[i*LW +: LW] = LW'($urandom);
            end
            m_valid_i[r] = v;
            m_data_i[r*DW +: DW] = v ? d[k] : $urandom;
            s_ready_i = rdy;
            @(posedge clk); #1;
            if (v && rdy) begin
                k++;
                model_rem--;
            end
            guard++;
        end
        if (k < eff) chk("burst_timeout", 64'(k), 64'(eff));
        model_active = 0;
        m_valid_i = '0;
    endtask

    task automatic mid_burst_stall();
        // Requester 0, four beats; valid drops for two cycles after beat one.
        logic [31:0] d[4];
        bit vs[7] = '{1, 0, 0, 1, 1, 1, 0};
        int k = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = 32'hC0DE_0000 + 32'(i);
            exp_beats.push_back('{id: 0, data: d[i], last: (i == 3)});
        end
        exp_grants.push_back(4);
        m_valid_i = 4'b1001;
        m_len_i = '0;
        m_len_i[0 +: LW] = 3'd4;
        s_ready_i = 1'b1;
        pick = 0; grant_en = 1; model_grant = 1;
        @(posedge clk); #1;
        grant_en = 0; model_grant = 0;
        model_active = 1; model_r = 0; model_rem = 4;
        for (int c = 0; c < 7 && k < 4; c++) begin
            m_valid_i[0] = vs[c] || (c == 6);
            m_data_i[0 +: DW] = d[k];
            @(posedge clk); #1;
            if (m_valid_i[0]) begin k++; model_rem--; end
        end
        chk("stall_beats", 64'(k), 64'(4));
        model_active = 0;
        m_valid_i = '0;
    endtask

    task automatic wrr_run();
        int seq[$];
        int g;
        for (int rnd = 0; rnd < 2; rnd++)
            for (int r = 0; r < N; r++)
                for (int w = 0; w < weights[r]; w++) seq.push_back(r);
        foreach (seq[i]) begin
            exp_grants.push_back(1);
            exp_beats.push_back('{id: seq[i], data: 32'hD000_0000 + 32'(seq[i]), last: 1'b1});
        end
        m_valid_i = '1;
        for (int i = 0; i < N; i++) begin
            m_len_i[i*LW +: LW] = 3'd1;
            m_data_i[i*DW +: DW] = 32'hD000_0000 + 32'(i);
        end
        s_ready_i = 1'b1;
        wrr_mode = 1;
        g = 0;
        foreach (seq[i]) begin
            model_grant = 1;
            @(posedge clk); #1;
            model_grant = 0;
            model_active = 1; model_r = seq[i]; model_rem = 1;
            @(posedge clk); #1;
            model_active = 0;
            g++;
        end
        chk("wrr_grants", 64'(g), 64'(seq.size()));
        wrr_mode = 0;
        m_valid_i = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_valid_i = '0;
        m_data_i = '0;
        m_len_i = '0;
        s_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_valid_i = 4'b1010;
        s_ready_i = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {m_ready_o, 1'b0, s_valid_o, s_last_o, arb_grant_ready_o,
                              4'(arb_num_grant_req_o)}, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid_i = '0;
        @(posedge clk); #1;

        do_burst(1, 3, 0, 0, -1);
        do_burst(2, 0, 0, 0, -1);
        do_burst(0, 4, 0, 1, -1);
        mid_burst_stall();
        do_burst(3, 7, 1, 1, -1);
        do_burst(2, 5, 0, 0, 2);
        do_burst(2, 5, 0, 0, -1);
        for (int i = 0; i < 60; i++) begin
            do_burst($urandom_range(0, N - 1), $urandom_range(0, 7),
                     ($urandom_range(0, 5) == 0), 1, -1);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end
        wrr_run();
        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", 64'(exp_beats.size() + exp_grants.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
